// File: rtl/game_turn_controller.sv
// game_turn_controller
// Mastermind game sequencer: alternates code-maker / code-breaker roles every
// round, counts guesses, accumulates the maker's score and declares a winner.
// Every output is decoded from registered state only.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   S_IDLE       | after reset, waiting for the first start_btn
//   S_MAKE       | maker (maker_a selects who) is locking the secret code
//   S_BREAK      | breaker is guessing, guess_count counts attempts
//   S_ROUND_END  | one-cycle round_done, roles swap on the next edge
//   S_GAME_OVER  | all rounds played, scores and winner flags hold
module game_turn_controller #(
  parameter int MAX_GUESSES = 10,
  parameter int ROUNDS      = 4,
  parameter int SCORE_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               code_entered,
  input  logic               guess_submitted,
  input  logic               guess_correct,
  output logic               started,
  output logic               active_p,
  output logic               take_code,
  output logic [3:0]         guess_count,
  output logic [3:0]         round_num,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               round_done,
  output logic               game_over,
  output logic               winner_a,
  output logic               winner_b,
  output logic               tie
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MAKE      = 3'd1,
    S_BREAK     = 3'd2,
    S_ROUND_END = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0]         MAX_G      = 4'(MAX_GUESSES);
  localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  // Wide enough for the largest score plus the largest per-round award (16).
  localparam int                 SUM_W      = ((SCORE_W > 5) ? SCORE_W : 5) + 1;

  state_t             state_q, state_d;
  logic               maker_a_q, maker_a_d;
  logic [3:0]         guess_count_q, guess_count_d;
  logic [3:0]         round_num_q, round_num_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;

  logic [3:0] guess_inc;
  logic [4:0] round_points;
  logic       start_game;
  logic       round_ends;

  // Saturating add so a long game pins the score at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [4:0]         b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(SCORE_MAX)) begin
      return SCORE_MAX;
    end
    return sum[SCORE_W-1:0];
  endfunction

  assign guess_inc    = guess_count_q + 4'd1;
  // A round lost by the breaker costs one extra point on top of the guesses used.
  assign round_points = 5'(guess_inc) + 5'(!guess_correct);
  assign start_game   = start_btn && ((state_q == S_IDLE) || (state_q == S_GAME_OVER));
  assign round_ends   = (state_q == S_BREAK) && guess_submitted &&
                        (guess_correct || (guess_inc == MAX_G));

  // State and datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      maker_a_q     <= 1'b1;
      guess_count_q <= 4'd0;
      round_num_q   <= 4'd0;
      score_a_q     <= '0;
      score_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      maker_a_q     <= maker_a_d;
      guess_count_q <= guess_count_d;
      round_num_q   <= round_num_d;
      score_a_q     <= score_a_d;
      score_b_q     <= score_b_d;
    end
  end

  // Next-state logic; inputs not legal in the current state fall through unused.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_btn) state_d = S_MAKE;
      end
      S_MAKE: begin
        if (code_entered) state_d = S_BREAK;
      end
      S_BREAK: begin
        if (round_ends) state_d = S_ROUND_END;
      end
      S_ROUND_END: begin
        state_d = (round_num_q == LAST_ROUND) ? S_GAME_OVER : S_MAKE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, role and score updates that accompany the state transitions.
  always_comb begin
    maker_a_d     = maker_a_q;
    guess_count_d = guess_count_q;
    round_num_d   = round_num_q;
    score_a_d     = score_a_q;
    score_b_d     = score_b_q;
    if (start_game) begin
      maker_a_d     = 1'b1;
      guess_count_d = 4'd0;
      round_num_d   = 4'd0;
      score_a_d     = '0;
      score_b_d     = '0;
    end else if ((state_q == S_BREAK) && guess_submitted) begin
      guess_count_d = guess_inc;
      if (round_ends) begin
        if (maker_a_q) begin
          score_a_d = sat_add(score_a_q, round_points);
        end else begin
          score_b_d = sat_add(score_b_q, round_points);
        end
      end
    end else if (state_q == S_ROUND_END) begin
      guess_count_d = 4'd0;
      maker_a_d     = ~maker_a_q;
      round_num_d   = round_num_q + 4'd1;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    started    = 1'b0;
    active_p   = 1'b0;
    take_code  = 1'b0;
    round_done = 1'b0;
    game_over  = 1'b0;
    winner_a   = 1'b0;
    winner_b   = 1'b0;
    tie        = 1'b0;
    case (state_q)
      S_MAKE: begin
        started   = 1'b1;
        take_code = 1'b1;
        active_p  = maker_a_q;
      end
      S_BREAK: begin
        started  = 1'b1;
        active_p = ~maker_a_q;
      end
      S_ROUND_END: begin
        started    = 1'b1;
        round_done = 1'b1;
        active_p   = ~maker_a_q;
      end
      S_GAME_OVER: begin
        game_over = 1'b1;
        winner_a  = (score_a_q > score_b_q);
        winner_b  = (score_b_q > score_a_q);
        tie       = (score_a_q == score_b_q);
      end
      default: ;
    endcase
  end

  assign guess_count = guess_count_q;
  assign round_num   = round_num_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller: a default-parameter instance runs
// the role/score/game flow, a SCORE_W=3 instance exercises score saturation.
module tb_game_turn_controller;

  logic       clk;
  logic       reset;
  logic       start_btn, code_entered, guess_submitted, guess_correct;
  logic       started, active_p, take_code, round_done, game_over;
  logic       winner_a, winner_b, tie;
  logic [3:0] guess_count, round_num;
  logic [5:0] score_a, score_b;

  logic       s_start_btn, s_code_entered, s_guess_submitted, s_guess_correct;
  logic       s_started, s_active_p, s_take_code, s_round_done, s_game_over;
  logic       s_winner_a, s_winner_b, s_tie;
  logic [3:0] s_guess_count, s_round_num;
  logic [2:0] s_score_a, s_score_b;

  logic [4:0] flags;
  assign flags = {started, active_p, take_code, round_done, game_over};

  int checks = 0;
  int errors = 0;

  game_turn_controller #(.MAX_GUESSES(10), .ROUNDS(4), .SCORE_W(6)) u_dut (
    .clk(clk), .reset(reset),
    .start_btn(start_btn), .code_entered(code_entered),
    .guess_submitted(guess_submitted), .guess_correct(guess_correct),
    .started(started), .active_p(active_p), .take_code(take_code),
    .guess_count(guess_count), .round_num(round_num),
    .score_a(score_a), .score_b(score_b),
    .round_done(round_done), .game_over(game_over),
    .winner_a(winner_a), .winner_b(winner_b), .tie(tie)
  );

  game_turn_controller #(.MAX_GUESSES(10), .ROUNDS(4), .SCORE_W(3)) u_sat (
    .clk(clk), .reset(reset),
    .start_btn(s_start_btn), .code_entered(s_code_entered),
    .guess_submitted(s_guess_submitted), .guess_correct(s_guess_correct),
    .started(s_started), .active_p(s_active_p), .take_code(s_take_code),
    .guess_count(s_guess_count), .round_num(s_round_num),
    .score_a(s_score_a), .score_b(s_score_b),
    .round_done(s_round_done), .game_over(s_game_over),
    .winner_a(s_winner_a), .winner_b(s_winner_b), .tie(s_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on the main instance; returns 1ns after the edge.
  task automatic cyc(input logic st, input logic ce, input logic gs, input logic gc);
    start_btn = st; code_entered = ce; guess_submitted = gs; guess_correct = gc;
    @(posedge clk);
    #1;
    start_btn = 0; code_entered = 0; guess_submitted = 0; guess_correct = 0;
  endtask

  task automatic scyc(input logic st, input logic ce, input logic gs, input logic gc);
    s_start_btn = st; s_code_entered = ce; s_guess_submitted = gs; s_guess_correct = gc;
    @(posedge clk);
    #1;
    s_start_btn = 0; s_code_entered = 0; s_guess_submitted = 0; s_guess_correct = 0;
  endtask

  // Code entry, some wrong guesses, one correct guess, then the ROUND_END cycle.
  task automatic play_round(input int wrong);
    cyc(0, 1, 0, 0);
    repeat (wrong) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b00000 || {winner_a, winner_b, tie} !== 3'b000 ||
        guess_count !== 4'd0 || round_num !== 4'd0 || score_a !== 6'd0 || score_b !== 6'd0) begin
      errors++;
      $display("FAIL reset_state flags=%b win=%b%b%b gc=%0d rn=%0d sa=%0d sb=%0d expected all 0",
               flags, winner_a, winner_b, tie, guess_count, round_num, score_a, score_b);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    checks++;
    if (guess_count !== 4'd3 || flags !== 5'b10000) begin
      errors++;
      $display("FAIL pre_reset_break gc=%0d flags=%b expected gc=3 flags=10000", guess_count, flags);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b00000 || guess_count !== 4'd0 || round_num !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_mid_break flags=%b gc=%0d rn=%0d expected 0", flags, guess_count, round_num);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b11100 || score_a !== 6'd0 || score_b !== 6'd0 || guess_count !== 4'd0) begin
      errors++;
      $display("FAIL start_after_reset flags=%b sa=%0d sb=%0d gc=%0d expected flags=11100 scores 0 gc 0",
               flags, score_a, score_b, guess_count);
    end
  endtask

  task automatic test_round0;
    cyc(0, 1, 0, 0);
    checks++;
    if (flags !== 5'b10000) begin
      errors++;
      $display("FAIL r0_break_entry flags=%b expected 10000", flags);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (guess_count !== 4'd2 || flags !== 5'b10000) begin
      errors++;
      $display("FAIL r0_two_wrong gc=%0d flags=%b expected gc=2 flags=10000", guess_count, flags);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if (flags !== 5'b10010 || guess_count !== 4'd3 || score_a !== 6'd3 || score_b !== 6'd0) begin
      errors++;
      $display("FAIL r0_round_end flags=%b gc=%0d sa=%0d sb=%0d expected flags=10010 gc=3 sa=3 sb=0",
               flags, guess_count, score_a, score_b);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (flags !== 5'b10100 || round_num !== 4'd1 || guess_count !== 4'd0) begin
      errors++;
      $display("FAIL r1_make flags=%b rn=%0d gc=%0d expected flags=10100 rn=1 gc=0", flags, round_num, guess_count);
    end
  endtask

  task automatic test_illegal;
    cyc(0, 0, 1, 1);
    checks++;
    if (flags !== 5'b10100 || guess_count !== 4'd0) begin
      errors++;
      $display("FAIL guess_in_make flags=%b gc=%0d expected flags=10100 gc=0", flags, guess_count);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b10100 || round_num !== 4'd1 || score_a !== 6'd3) begin
      errors++;
      $display("FAIL start_in_make flags=%b rn=%0d sa=%0d expected flags=10100 rn=1 sa=3", flags, round_num, score_a);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    checks++;
    if (flags !== 5'b11000 || guess_count !== 4'd0) begin
      errors++;
      $display("FAIL code_in_break flags=%b gc=%0d expected flags=11000 gc=0", flags, guess_count);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b11000 || round_num !== 4'd1 || score_a !== 6'd3) begin
      errors++;
      $display("FAIL start_in_break flags=%b rn=%0d sa=%0d expected flags=11000 rn=1 sa=3", flags, round_num, score_a);
    end
  endtask

  task automatic test_max_guesses;
    cyc(0, 1, 1, 0);
    checks++;
    if (guess_count !== 4'd1 || flags !== 5'b11000) begin
      errors++;
      $display("FAIL same_edge_in_break gc=%0d flags=%b expected gc=1 flags=11000", guess_count, flags);
    end
    repeat (8) cyc(0, 0, 1, 0);
    checks++;
    if (guess_count !== 4'd9 || flags !== 5'b11000) begin
      errors++;
      $display("FAIL nine_wrong gc=%0d flags=%b expected gc=9 flags=11000", guess_count, flags);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (flags !== 5'b11010 || guess_count !== 4'd10 || score_b !== 6'd11 || score_a !== 6'd3) begin
      errors++;
      $display("FAIL r1_out_of_guesses flags=%b gc=%0d sa=%0d sb=%0d expected flags=11010 gc=10 sa=3 sb=11",
               flags, guess_count, score_a, score_b);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (flags !== 5'b11100 || guess_count !== 4'd0 || round_num !== 4'd2) begin
      errors++;
      $display("FAIL r2_make flags=%b gc=%0d rn=%0d expected flags=11100 gc=0 rn=2", flags, guess_count, round_num);
    end
  endtask

  task automatic test_game_end;
    cyc(0, 1, 1, 1);
    checks++;
    if (flags !== 5'b10000 || guess_count !== 4'd0) begin
      errors++;
      $display("FAIL same_edge_in_make flags=%b gc=%0d expected flags=10000 gc=0", flags, guess_count);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if (flags !== 5'b10010 || score_a !== 6'd4) begin
      errors++;
      $display("FAIL r2_first_guess flags=%b sa=%0d expected flags=10010 sa=4", flags, score_a);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    checks++;
    if (flags !== 5'b11010 || score_b !== 6'd12) begin
      errors++;
      $display("FAIL r3_round_end flags=%b sb=%0d expected flags=11010 sb=12", flags, score_b);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b00001 || {winner_a, winner_b, tie} !== 3'b010 || round_num !== 4'd4) begin
      errors++;
      $display("FAIL game_over_b_wins flags=%b win=%b%b%b rn=%0d expected flags=00001 win=010 rn=4",
               flags, winner_a, winner_b, tie, round_num);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (flags !== 5'b00001 || score_a !== 6'd4 || score_b !== 6'd12 || winner_b !== 1'b1) begin
      errors++;
      $display("FAIL game_over_hold flags=%b sa=%0d sb=%0d wb=%b expected flags=00001 sa=4 sb=12 wb=1",
               flags, score_a, score_b, winner_b);
    end
  endtask

  task automatic test_tie_game;
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b11100 || score_a !== 6'd0 || score_b !== 6'd0 || round_num !== 4'd0) begin
      errors++;
      $display("FAIL restart_clears flags=%b sa=%0d sb=%0d rn=%0d expected flags=11100 scores 0 rn 0",
               flags, score_a, score_b, round_num);
    end
    play_round(1);
    play_round(1);
    play_round(4);
    checks++;
    if (score_a !== 6'd7 || score_b !== 6'd2 || round_num !== 4'd3) begin
      errors++;
      $display("FAIL tie_mid_game sa=%0d sb=%0d rn=%0d expected sa=7 sb=2 rn=3", score_a, score_b, round_num);
    end
    play_round(4);
    checks++;
    if (flags !== 5'b00001 || {winner_a, winner_b, tie} !== 3'b001 || score_a !== 6'd7 || score_b !== 6'd7) begin
      errors++;
      $display("FAIL tie_game_over flags=%b win=%b%b%b sa=%0d sb=%0d expected flags=00001 win=001 sa=7 sb=7",
               flags, winner_a, winner_b, tie, score_a, score_b);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (flags !== 5'b11100 || score_a !== 6'd0 || score_b !== 6'd0 || {winner_a, winner_b, tie} !== 3'b000) begin
      errors++;
      $display("FAIL new_game_after_tie flags=%b sa=%0d sb=%0d win=%b%b%b expected flags=11100 scores 0 win 000",
               flags, score_a, score_b, winner_a, winner_b, tie);
    end
  endtask

  task automatic test_saturation;
    scyc(1, 0, 0, 0);
    scyc(0, 1, 0, 0);
    repeat (10) scyc(0, 0, 1, 0);
    checks++;
    if (s_score_a !== 3'd7 || s_round_done !== 1'b1 || s_guess_count !== 4'd10) begin
      errors++;
      $display("FAIL sat_first_round sa=%0d rd=%b gc=%0d expected sa=7 rd=1 gc=10", s_score_a, s_round_done, s_guess_count);
    end
    scyc(0, 0, 0, 0);
    scyc(0, 1, 0, 0);
    scyc(0, 0, 1, 1);
    scyc(0, 0, 0, 0);
    scyc(0, 1, 0, 0);
    repeat (10) scyc(0, 0, 1, 0);
    checks++;
    if (s_score_a !== 3'd7 || s_score_b !== 3'd1 || s_round_done !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold sa=%0d sb=%0d rd=%b expected sa=7 sb=1 rd=1", s_score_a, s_score_b, s_round_done);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_btn = 0; code_entered = 0; guess_submitted = 0; guess_correct = 0;
    s_start_btn = 0; s_code_entered = 0; s_guess_submitted = 0; s_guess_correct = 0;
    test_reset();
    test_round0();
    test_illegal();
    test_max_guesses();
    test_game_end();
    test_tie_game();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
